// File: rtl/pipe_decoder.sv
`default_nettype none
// ============================================================================
// Module      : pipe_decoder
// Description : Registered address-to-one-hot decoder with a self-timed sweep
//               mode that steps the one-hot select through every index.
//               With ZERO_MASK set, select bit 0 never asserts: a single
//               decode of address 0 is dropped, and a sweep starts at index 1.
// Ports       : clock       - single clock, rising edge
//               reset       - asynchronous active-high reset
//               req         - request a single decode of addr
//               addr        - address to decode (ADDR_W bits)
//               sweep_start - request a sweep over all indices
//               out         - registered one-hot (or all-zero) select
//               out_valid   - out holds exactly one asserted bit
//               index       - binary index of the asserted bit (holds when idle)
//               busy        - sweep in progress
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_decoder #(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned ZERO_MASK = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req,
  input  logic [ADDR_W-1:0]        addr,
  input  logic                     sweep_start,
  output logic [(1<<ADDR_W)-1:0]   out,
  output logic                     out_valid,
  output logic [ADDR_W-1:0]        index,
  output logic                     busy
);

  localparam int unsigned OUT_W = 1 << ADDR_W;

  // A sweep skips the masked index 0; the final index is all ones, so the
  // counter stops there and never wraps.
  localparam logic [ADDR_W-1:0] FIRST_IDX = (ZERO_MASK != 0) ? ADDR_W'(1) : ADDR_W'(0);
  localparam logic [ADDR_W-1:0] LAST_IDX  = {ADDR_W{1'b1}};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] index_q, index_d;

  function automatic logic [OUT_W-1:0] onehot(input logic [ADDR_W-1:0] a);
    logic [OUT_W-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      out_q   <= '0;
      valid_q <= 1'b0;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      index_q <= index_d;
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = '0;
    valid_d = 1'b0;
    index_d = index_q;

    case (state_q)
      IDLE: begin
        // sweep_start wins over a simultaneous req; that req is discarded.
        if (sweep_start) begin
          state_d = SWEEP;
          out_d   = onehot(FIRST_IDX);
          valid_d = 1'b1;
          index_d = FIRST_IDX;
        end else if (req) begin
          if ((ZERO_MASK != 0) && (addr == '0)) begin
            // Decode of the hard-wired register: dropped, index reports 0.
            index_d = '0;
          end else begin
            out_d   = onehot(addr);
            valid_d = 1'b1;
            index_d = addr;
          end
        end
      end

      SWEEP: begin
        // Inputs are ignored for the whole sweep, including its last cycle.
        if (index_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          out_d   = onehot(index_q + ADDR_W'(1));
          valid_d = 1'b1;
          index_d = index_q + ADDR_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign index     = index_q;
  assign busy      = (state_q == SWEEP);

endmodule
`default_nettype wire

// File: tb/tb_pipe_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_decoder
// Description : Self-checking bench for pipe_decoder. Two instances share all
//               inputs: u_zm1 (ZERO_MASK=1) and u_zm0 (ZERO_MASK=0). Each is
//               compared every checked cycle against a list-based reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_decoder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic [4:0]  addr = '0;
  logic        sweep_start = 1'b0;

  logic [31:0] out0, out1;
  logic        val0, val1, busy0, busy1;
  logic [4:0]  idx0, idx1;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pipe_decoder #(.ADDR_W(5), .ZERO_MASK(1)) u_zm1 (
    .clock(clock), .reset(reset), .req(req), .addr(addr), .sweep_start(sweep_start),
    .out(out0), .out_valid(val0), .index(idx0), .busy(busy0)
  );

  pipe_decoder #(.ADDR_W(5), .ZERO_MASK(0)) u_zm0 (
    .clock(clock), .reset(reset), .req(req), .addr(addr), .sweep_start(sweep_start),
    .out(out1), .out_valid(val1), .index(idx1), .busy(busy1)
  );

  // Observed state packed as {busy, out_valid, index, out}, instance 0 low.
  wire [77:0] obs = {busy1, val1, idx1, out1, busy0, val0, idx0, out0};

  // ---------------- reference model ----------------
  // A sweep is a list of indices still to be presented; each edge presents
  // the next one, and the edge after the list empties returns to idle.
  int m_idx  [2];
  bit m_val  [2];
  bit m_busy [2];
  int q0[$];
  int q1[$];

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int k = 0; k < 2; k++) begin
      m_idx[k] = 0; m_val[k] = 0; m_busy[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input int zm);
    int v;
    bit have;
    if (m_busy[k]) begin
      have = 0;
      v = 0;
      if (k == 0 && q0.size() > 0) begin v = q0.pop_front(); have = 1; end
      if (k == 1 && q1.size() > 0) begin v = q1.pop_front(); have = 1; end
      if (have) begin
        m_idx[k] = v; m_val[k] = 1;
      end else begin
        m_busy[k] = 0; m_val[k] = 0;
      end
    end else if (sweep_start) begin
      for (int i = zm + 1; i < 32; i++) begin
        if (k == 0) q0.push_back(i); else q1.push_back(i);
      end
      m_busy[k] = 1; m_val[k] = 1; m_idx[k] = zm;
    end else if (req) begin
      if (zm == 1 && addr == 0) begin
        m_val[k] = 0; m_idx[k] = 0;
      end else begin
        m_val[k] = 1; m_idx[k] = int'(addr);
      end
    end else begin
      m_val[k] = 0;
    end
  endtask

  function automatic logic [38:0] expv(input int k);
    logic [31:0] o;
    o = m_val[k] ? (32'd1 << m_idx[k]) : 32'd0;
    return {m_busy[k], m_val[k], 5'(m_idx[k]), o};
  endfunction

  // Advance one clock edge, update the model with the inputs seen at that
  // edge, then settle so outputs are sampled away from the edge.
  task automatic cyc();
    @(posedge clock);
    if (!reset) begin
      model_step(0, 1);
      model_step(1, 0);
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (obs !== 78'd0) begin
      errors++;
      $display("FAIL reset_async: got %h expected 0", obs);
    end
    // Put something in the outputs, then reset mid-cycle with no edge.
    @(negedge clock) reset = 1'b0;
    req = 1'b1; addr = 5'd9;
    cyc();
    req = 1'b0;
    #2 reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (obs !== {expv(1), expv(0)} || out0 !== 32'h0 || val0 !== 1'b0 || idx0 !== 5'd0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_midcycle: got %h expected %h", obs, {expv(1), expv(0)});
    end
    @(negedge clock) reset = 1'b0;
  endtask

  task automatic test_single();
    req = 1'b1; addr = 5'd7;
    cyc();
    req = 1'b0;
    checks++;
    if (obs !== {expv(1), expv(0)} || out0 !== 32'h0000_0080 || idx0 !== 5'd7 || val0 !== 1'b1) begin
      errors++;
      $display("FAIL single_decode: got %h expected %h", obs, {expv(1), expv(0)});
    end
    cyc();
    checks++;
    if (obs !== {expv(1), expv(0)} || out0 !== 32'h0 || val0 !== 1'b0 || idx0 !== 5'd7) begin
      errors++;
      $display("FAIL single_idle_hold: got %h expected %h", obs, {expv(1), expv(0)});
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  a   [3] = '{5'd3, 5'd31, 5'd0};
    logic [31:0] exo [3] = '{32'h0000_0008, 32'h8000_0000, 32'h0};
    for (int i = 0; i < 3; i++) begin
      req = 1'b1; addr = a[i];
      cyc();
      checks++;
      if (obs !== {expv(1), expv(0)} || out0 !== exo[i] || val0 !== (i != 2) ||
          idx0 !== ((i == 2) ? 5'd0 : a[i])) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %h expected %h", i, obs, {expv(1), expv(0)});
      end
    end
    req = 1'b0;
    cyc();
    checks++;
    if (obs !== {expv(1), expv(0)}) begin
      errors++;
      $display("FAIL back_to_back_idle: got %h expected %h", obs, {expv(1), expv(0)});
    end
  endtask

  task automatic test_sweep_priority();
    int n0, n1, i;
    n0 = 0; n1 = 0;
    sweep_start = 1'b1; req = 1'b1; addr = 5'd5;
    cyc();
    sweep_start = 1'b0; req = 1'b0;
    checks++;
    if (obs !== {expv(1), expv(0)} || out0 !== 32'h2 || idx0 !== 5'd1 || busy0 !== 1'b1 ||
        out1 !== 32'h1 || idx1 !== 5'd0 || busy1 !== 1'b1) begin
      errors++;
      $display("FAIL sweep_first: got %h expected %h", obs, {expv(1), expv(0)});
    end
    i = 0;
    while ((busy0 || busy1) && i < 40) begin
      if (busy0) n0++;
      if (busy1) n1++;
      if (busy0 && idx0 == 5'd31) begin
        checks++;
        if (out0 !== 32'h8000_0000) begin
          errors++;
          $display("FAIL sweep_last: got %h expected 80000000", out0);
        end
      end
      // Both still mid-sweep: stray requests must be ignored.
      if (i < 28) begin
        req = 1'($urandom_range(0, 1));
        addr = 5'($urandom);
        sweep_start = 1'($urandom_range(0, 1));
      end else begin
        req = 1'b0; sweep_start = 1'b0;
      end
      cyc();
      checks++;
      if (obs !== {expv(1), expv(0)}) begin
        errors++;
        $display("FAIL sweep_step[%0d]: got %h expected %h", i, obs, {expv(1), expv(0)});
      end
      i++;
    end
    checks++;
    if (n0 !== 31 || n1 !== 32) begin
      errors++;
      $display("FAIL sweep_length: got zm1=%0d zm0=%0d expected 31 32", n0, n1);
    end
    checks++;
    if (out0 !== 32'h0 || busy0 !== 1'b0 || idx0 !== 5'd31 || out1 !== 32'h0 || idx1 !== 5'd31) begin
      errors++;
      $display("FAIL sweep_end: got %h expected zero outputs index 31", obs);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int i;
    sweep_start = 1'b1;
    cyc();
    sweep_start = 1'b0;
    i = 0;
    while (idx0 != 5'd10 && i < 40) begin
      cyc();
      i++;
    end
    checks++;
    if (idx0 !== 5'd10 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL sweep_reach10: got index %0d busy %b expected 10 1", idx0, busy0);
    end
    #2 reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (obs !== 78'd0) begin
      errors++;
      $display("FAIL reset_in_sweep: got %h expected 0", obs);
    end
    @(negedge clock) reset = 1'b0;
    req = 1'b1; addr = 5'd2;
    cyc();
    req = 1'b0;
    checks++;
    if (obs !== {expv(1), expv(0)} || out0 !== 32'h4 || busy0 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_req: got %h expected %h", obs, {expv(1), expv(0)});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      sweep_start = ($urandom_range(0, 19) == 0);
      req = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      cyc();
      checks++;
      if (obs !== {expv(1), expv(0)}) begin
        errors++;
        $display("FAIL random[%0d]: got %h expected %h", i, obs, {expv(1), expv(0)});
      end
      checks++;
      if ((out0 & (out0 - 32'd1)) !== 32'd0 || out0[0] !== 1'b0 || (out1 & (out1 - 32'd1)) !== 32'd0) begin
        errors++;
        $display("FAIL random_onehot[%0d]: got %h %h expected at most one bit, bit0 clear", i, out0, out1);
      end
    end
    sweep_start = 1'b0; req = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_sweep_priority();
    test_reset_mid_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
